// File: rtl/cipher_pkg.sv
// Shared definitions for the LFSR stream cipher: default geometry, FSM state
// encoding and the keystream step used identically on transmit and receive.
package cipher_pkg;

  localparam int DEFAULT_BLOCK_SIZE = 32;
  // Feedback from state bits 32 and 19.
  localparam logic [DEFAULT_BLOCK_SIZE:0] DEFAULT_TAPS = 33'h1_0008_0000;

  // Widest LFSR state the shared step function handles (BLOCK_SIZE <= 63).
  localparam int LFSR_MAX_W = 64;
  typedef logic [LFSR_MAX_W-1:0] lfsr_word_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEED  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } cipher_state_e;

  // One Fibonacci step. State and taps arrive zero-extended to LFSR_MAX_W;
  // the caller keeps the low bits that belong to its own state width, so the
  // bit shifted into the unused upper region is simply dropped.
  function automatic lfsr_word_t lfsr_step(input lfsr_word_t state, input lfsr_word_t taps);
    return {state[LFSR_MAX_W-2:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/lfsr_stream_decrypt_if.sv
// Ciphertext-in / plaintext-out streaming bus with valid/ready on each side.
// master: link-side producer of ciphertext and consumer of plaintext.
// slave : the decryptor.
interface lfsr_stream_decrypt_if #(
  parameter int BLOCK_SIZE = 32
);
  logic                  ct_valid;
  logic                  ct_ready;
  logic [BLOCK_SIZE-1:0] ct_data;
  logic                  ct_last;
  logic                  pt_valid;
  logic                  pt_ready;
  logic [BLOCK_SIZE-1:0] pt_data;
  logic                  pt_last;

  modport master (
    output ct_valid, ct_data, ct_last, pt_ready,
    input  ct_ready, pt_valid, pt_data, pt_last
  );

  modport slave (
    input  ct_valid, ct_data, ct_last, pt_ready,
    output ct_ready, pt_valid, pt_data, pt_last
  );
endinterface

// File: rtl/lfsr_core.sv
// Keystream generator shared with the transmit path: a BLOCK_SIZE+1 bit
// Fibonacci LFSR that loads a seed and advances once per enabled step.
// The low BLOCK_SIZE bits of the current state are the keystream word.
module lfsr_core
  import cipher_pkg::*;
#(
  parameter int                    BLOCK_SIZE = DEFAULT_BLOCK_SIZE,
  parameter logic [BLOCK_SIZE:0]   TAPS       = DEFAULT_TAPS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [BLOCK_SIZE:0]   seed_i,
  input  logic                  step_i,
  output logic [BLOCK_SIZE-1:0] keystream_o
);

  typedef logic [BLOCK_SIZE:0] state_t;

  state_t state_q, state_d;

  // Next state: a load wins over a step; an all-zero seed would lock the
  // LFSR, so it is replaced by 1.
  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    if (load_i) begin
      state_d = (seed_i == '0) ? {{BLOCK_SIZE{1'b0}}, 1'b1} : seed_i;
    end else if (step_i) begin
      state_d = state_t'(lfsr_step(lfsr_word_t'(state_q), lfsr_word_t'(TAPS)));
    end
  end

  // State register, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    if (!rst_n) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign keystream_o = state_q[BLOCK_SIZE-1:0];

endmodule

// File: rtl/lfsr_stream_decrypt.sv
// Receive side of the LFSR stream cipher. Regenerates the transmit keystream
// from the shared seed, XORs it onto each accepted ciphertext block and
// presents the plaintext with one cycle of latency at one block per cycle.
module lfsr_stream_decrypt
  import cipher_pkg::*;
#(
  parameter int                  BLOCK_SIZE = DEFAULT_BLOCK_SIZE,
  parameter logic [BLOCK_SIZE:0] TAPS       = DEFAULT_TAPS,
  parameter int                  CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_load_i,
  input  logic [BLOCK_SIZE:0]  key_i,
  lfsr_stream_decrypt_if.slave bus,
  output logic                 busy_o,
  output logic [CNT_W-1:0]     blk_count_o
);

  cipher_state_e         state_q;
  logic                  pt_valid_q;
  logic [BLOCK_SIZE-1:0] pt_data_q;
  logic                  pt_last_q;
  logic [CNT_W-1:0]      blk_count_q;

  logic [BLOCK_SIZE-1:0] keystream;
  logic                  ct_ready;
  logic                  ct_accept;
  logic                  pt_accept;

  // Accept a new block while running if the output slot is free or draining
  // this cycle; a key_load cycle never accepts, since the frame restarts.
  assign ct_ready  = (state_q == ST_RUN) && (!pt_valid_q || bus.pt_ready) && !key_load_i;
  assign ct_accept = bus.ct_valid && ct_ready;
  assign pt_accept = pt_valid_q && bus.pt_ready;

  // The seed is captured on the key_load edge so the key only has to be valid
  // alongside the pulse; the SEED cycle is the frame-start bubble. The LFSR
  // advances only on accepted beats, so stalls never skip keystream.
  lfsr_core #(
    .BLOCK_SIZE (BLOCK_SIZE),
    .TAPS       (TAPS)
  ) u_lfsr_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (key_load_i),
    .seed_i      (key_i),
    .step_i      (ct_accept),
    .keystream_o (keystream)
  );

  // Frame FSM with registered plaintext slot and block counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pt_valid_q  <= 1'b0;
      pt_data_q   <= '0;
      pt_last_q   <= 1'b0;
      blk_count_q <= '0;
    end else if (key_load_i) begin
      // Start or abort-and-restart: any in-flight plaintext is discarded.
      state_q    <= ST_SEED;
      pt_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_SEED: begin
          blk_count_q <= '0;
          state_q     <= ST_RUN;
        end
        ST_RUN: begin
          if (ct_accept) begin
            pt_data_q   <= bus.ct_data ^ keystream;
            pt_last_q   <= bus.ct_last;
            pt_valid_q  <= 1'b1;
            blk_count_q <= blk_count_q + CNT_W'(1);
            if (bus.ct_last) begin
              state_q <= ST_DRAIN;
            end
          end else if (pt_accept) begin
            pt_valid_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (!pt_valid_q || bus.pt_ready) begin
            pt_valid_q <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.ct_ready = ct_ready;
  assign bus.pt_valid = pt_valid_q;
  assign bus.pt_data  = pt_data_q;
  assign bus.pt_last  = pt_last_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign blk_count_o  = blk_count_q;

endmodule

// File: tb/tb_lfsr_stream_decrypt.sv
// Self-checking bench for lfsr_stream_decrypt: hand-computed vector table,
// directed corner sequences and a randomized loopback against a keystream
// model built from the cipher's arithmetic definition.
module tb_lfsr_stream_decrypt;

  localparam logic [32:0] TAPS_M = 33'h1_0008_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_load;
  logic [32:0] key;
  logic        busy, busy_n;
  logic [15:0] cnt;
  logic [3:0]  cnt_n;

  lfsr_stream_decrypt_if #(.BLOCK_SIZE(32)) bus ();
  lfsr_stream_decrypt_if #(.BLOCK_SIZE(32)) bus_n ();

  // Narrow-counter copy sees exactly the same traffic.
  assign bus_n.ct_valid = bus.ct_valid;
  assign bus_n.ct_data  = bus.ct_data;
  assign bus_n.ct_last  = bus.ct_last;
  assign bus_n.pt_ready = bus.pt_ready;

  lfsr_stream_decrypt dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_load_i  (key_load),
    .key_i       (key),
    .bus         (bus),
    .busy_o      (busy),
    .blk_count_o (cnt)
  );

  lfsr_stream_decrypt #(.CNT_W(4)) dut_n (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_load_i  (key_load),
    .key_i       (key),
    .bus         (bus_n),
    .busy_o      (busy_n),
    .blk_count_o (cnt_n)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Keystream model: next state is the state doubled (modulo 2^33) plus the
  // parity of the tapped bits.
  function automatic logic [32:0] m_step(input logic [32:0] s);
    return (s << 1) | 33'($countones(s & TAPS_M) % 2);
  endfunction

  logic [31:0] pt_arr [1024];
  logic [31:0] ct_arr [1024];

  // Transmit-side model: random plaintext encrypted with the seed's keystream.
  task automatic build_frame(input logic [32:0] seed, input int n);
    logic [32:0] s;
    s = (seed == '0) ? 33'd1 : seed;
    for (int i = 0; i < n; i++) begin
      pt_arr[i] = $urandom;
      ct_arr[i] = pt_arr[i] ^ s[31:0];
      s = m_step(s);
    end
  endtask

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic do_key_load(input logic [32:0] k);
    key_load = 1'b1;
    key      = k;
    @(posedge clk); #1;
    key_load = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_block(input string name, input logic [31:0] ct, input logic [31:0] exp_pt,
                            input bit last, input bit consume, input int exp_cnt);
    bus.ct_valid = 1'b1;
    bus.ct_data  = ct;
    bus.ct_last  = last;
    bus.pt_ready = 1'b1;
    @(negedge clk);
    check({name, "_ct_ready"}, bus.ct_ready, 1);
    @(posedge clk); #1;
    bus.ct_valid = 1'b0;
    bus.ct_last  = 1'b0;
    bus.pt_ready = consume;
    @(negedge clk);
    check({name, "_pt"}, {bus.pt_valid, bus.pt_last, bus.pt_data}, {1'b1, last, exp_pt});
    check({name, "_cnt"}, cnt, exp_cnt);
    @(posedge clk); #1;
  endtask

  // Streams ct_arr[0..n-1] with random stalls and checks every plaintext in order.
  task automatic stream(input int n, input int last_at, input int vstall, input int rstall,
                        output int cyc);
    int sent, rx;
    sent = 0;
    rx   = 0;
    cyc  = 0;
    while (rx < n && cyc < 40 * n + 100) begin
      bus.ct_valid = (sent < n) && (int'($urandom_range(99)) >= vstall);
      bus.ct_data  = (sent < n) ? ct_arr[sent] : 32'h0;
      bus.ct_last  = (sent == last_at);
      bus.pt_ready = (int'($urandom_range(99)) >= rstall);
      @(negedge clk);
      if (bus.pt_valid && bus.pt_ready) begin
        check($sformatf("stream_pt_%0d", rx), {bus.pt_last, bus.pt_data},
              {(rx == last_at), pt_arr[rx]});
        rx++;
      end
      if (bus.ct_valid && bus.ct_ready) sent++;
      cyc++;
      @(posedge clk); #1;
    end
    check("stream_complete", rx, n);
    bus.ct_valid = 1'b0;
    bus.ct_last  = 1'b0;
    bus.pt_ready = 1'b0;
  endtask

  typedef struct {
    logic [32:0] key;
    bit          new_frame;
    logic [31:0] ct;
    logic [31:0] pt;
  } vec_t;

  vec_t vecs [15];

  initial begin
    int cyc, fcnt;
    logic [31:0] held;

    // Key 1: state after n steps is 1<<n for small n. Key 0 must match key 1.
    // Key 2^32: keystream 0, then feedback bit gives 1, then 2.
    vecs[0]  = '{33'h1,           1'b1, 32'hDEADBEEF, 32'hDEADBEEE};
    vecs[1]  = '{33'h1,           1'b0, 32'h00000002, 32'h00000000};
    vecs[2]  = '{33'h1,           1'b0, 32'hFFFFFFFF, 32'hFFFFFFFB};
    vecs[3]  = '{33'h1,           1'b0, 32'h12345678, 32'h12345670};
    vecs[4]  = '{33'h1,           1'b0, 32'h00000000, 32'h00000010};
    vecs[5]  = '{33'h1,           1'b0, 32'hA5A5A5A5, 32'hA5A5A585};
    vecs[6]  = '{33'h0,           1'b1, 32'hDEADBEEF, 32'hDEADBEEE};
    vecs[7]  = '{33'h0,           1'b0, 32'h00000002, 32'h00000000};
    vecs[8]  = '{33'h0,           1'b0, 32'hFFFFFFFF, 32'hFFFFFFFB};
    vecs[9]  = '{33'h0,           1'b0, 32'h12345678, 32'h12345670};
    vecs[10] = '{33'h0,           1'b0, 32'h00000000, 32'h00000010};
    vecs[11] = '{33'h0,           1'b0, 32'hA5A5A5A5, 32'hA5A5A585};
    vecs[12] = '{33'h1_0000_0000, 1'b1, 32'h11111111, 32'h11111111};
    vecs[13] = '{33'h1_0000_0000, 1'b0, 32'h11111111, 32'h11111110};
    vecs[14] = '{33'h1_0000_0000, 1'b0, 32'h00000000, 32'h00000002};

    key_load     = 1'b0;
    key          = '0;
    bus.ct_valid = 1'b0;
    bus.ct_data  = '0;
    bus.ct_last  = 1'b0;
    bus.pt_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset_pt", {bus.pt_valid, bus.pt_last, bus.pt_data}, 0);
    check("reset_ct_ready", bus.ct_ready, 0);
    check("reset_busy", busy, 0);
    check("reset_cnt", cnt, 0);
    rst_n = 1'b1;

    // Leaving reset alone does not start decryption.
    bus.ct_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("idle_ct_ready", bus.ct_ready, 0);
    check("idle_busy", busy, 0);
    @(posedge clk); #1;
    bus.ct_valid = 1'b0;

    // Vector table.
    fcnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].new_frame) begin
        do_key_load(vecs[i].key);
        fcnt = 0;
      end
      fcnt++;
      send_block($sformatf("vec%0d", i), vecs[i].ct, vecs[i].pt, 1'b0, 1'b1, fcnt);
    end

    // Asynchronous reset mid-run with a block pending and ct_valid high.
    bus.ct_valid = 1'b1;
    bus.ct_data  = 32'h55AA55AA;
    bus.pt_ready = 1'b0;
    @(posedge clk); #1;
    check("prereset_pt_valid", bus.pt_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_pt", {bus.pt_valid, bus.pt_last, bus.pt_data}, 0);
    check("async_reset_ctl", {bus.ct_ready, busy, cnt}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.pt_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    check("postreset_ct_ready", bus.ct_ready, 0);
    @(posedge clk); #1;
    bus.ct_valid = 1'b0;
    do_key_load(33'h0_0BAD_F00D);
    @(negedge clk);
    check("run_ct_ready", bus.ct_ready, 1);
    @(posedge clk); #1;

    // Abort after 5 blocks while the 6th is held by pt_ready=0.
    do_key_load(33'h0_CAFE_F00D);
    build_frame(33'h0_CAFE_F00D, 7);
    for (int i = 0; i < 5; i++)
      send_block($sformatf("abort_blk%0d", i), ct_arr[i], pt_arr[i], 1'b0, 1'b1, i + 1);
    send_block("abort_blk5", ct_arr[5], pt_arr[5], 1'b0, 1'b0, 6);
    held = pt_arr[5];
    bus.ct_valid = 1'b1;
    bus.ct_data  = ct_arr[6];
    @(negedge clk);
    check("stall_ct_ready", bus.ct_ready, 0);
    check("stall_hold", {bus.pt_valid, bus.pt_data}, {1'b1, held});
    @(posedge clk); #1;
    key_load = 1'b1;
    key      = 33'h1_F0F0_1234;
    @(posedge clk); #1;
    key_load     = 1'b0;
    bus.ct_valid = 1'b0;
    @(negedge clk);
    check("abort_pt_valid", bus.pt_valid, 0);
    check("abort_busy", busy, 1);
    @(posedge clk); #1;
    build_frame(33'h1_F0F0_1234, 1);
    send_block("newframe_blk0", ct_arr[0], pt_arr[0], 1'b0, 1'b1, 1);

    // A ct beat in the key_load cycle is refused even with the slot free.
    key_load     = 1'b1;
    key          = 33'h0_1357_9BDF;
    bus.ct_valid = 1'b1;
    bus.ct_data  = 32'hFFFF0000;
    bus.pt_ready = 1'b1;
    @(negedge clk);
    check("keyload_ct_ready", bus.ct_ready, 0);
    @(posedge clk); #1;
    key_load     = 1'b0;
    bus.ct_valid = 1'b0;
    @(negedge clk);
    check("keyload_no_pt", bus.pt_valid, 0);
    @(posedge clk); #1;
    build_frame(33'h0_1357_9BDF, 1);
    send_block("ghost_blk0", ct_arr[0], pt_arr[0], 1'b0, 1'b1, 1);

    // key_load during SEED reloads the newer key and extends SEED.
    key_load = 1'b1;
    key      = 33'h0_1111_2222;
    @(posedge clk); #1;
    key      = 33'h1_3333_4444;
    @(posedge clk); #1;
    key_load = 1'b0;
    @(negedge clk);
    check("seed_reload_ct_ready", {bus.ct_ready, busy}, 2'b01);
    @(posedge clk); #1;
    build_frame(33'h1_3333_4444, 1);
    send_block("reseed_blk0", ct_arr[0], pt_arr[0], 1'b0, 1'b1, 1);

    // ct_last on block 3, DRAIN until pt_ready.
    do_key_load(33'h0_2468_ACE0);
    build_frame(33'h0_2468_ACE0, 4);
    for (int i = 0; i < 3; i++)
      send_block($sformatf("last_blk%0d", i), ct_arr[i], pt_arr[i], 1'b0, 1'b1, i + 1);
    send_block("last_blk3", ct_arr[3], pt_arr[3], 1'b1, 1'b0, 4);
    bus.ct_valid = 1'b1;
    bus.ct_data  = 32'h0F0F0F0F;
    repeat (2) begin
      @(negedge clk);
      check("drain_hold", {busy, bus.ct_ready, bus.pt_valid, bus.pt_last}, 4'b1011);
      @(posedge clk); #1;
    end
    bus.ct_valid = 1'b0;
    bus.pt_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("drain_done", {busy, bus.pt_valid}, 2'b00);
    check("drain_cnt", cnt, 4);
    @(posedge clk); #1;

    // 17 blocks back-to-back: one block per cycle, narrow counter wraps.
    do_key_load(33'h0_7777_0001);
    build_frame(33'h0_7777_0001, 17);
    stream(17, 16, 0, 0, cyc);
    check("throughput_cycles", cyc, 18);
    check("wrap_cnt_wide", cnt, 17);
    check("wrap_cnt_narrow", cnt_n, 1);
    check("wrap_narrow_pt", bus_n.pt_data, pt_arr[16]);
    check("wrap_idle", {busy, busy_n}, 2'b00);

    // Loopback: 1000 random blocks with random stalls on both sides.
    do_key_load(33'h1_2345_6789);
    build_frame(33'h1_2345_6789, 1000);
    stream(1000, 999, 30, 30, cyc);
    check("loopback_cnt", cnt, 1000);
    check("loopback_cnt_narrow", cnt_n, 8);
    check("loopback_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
